// File: rtl/softmax_pkg.sv
// softmax_pkg: shared fixed-point defaults, result record, state encoding and clog2 helper
package softmax_pkg;
    localparam int IN_FRAC_DEF = 16;
    localparam int OUT_FRAC_DEF = 11;
    localparam int OUT_W_DEF = 16;
    localparam int CNT_W_DEF = 12;
    typedef struct packed {
        logic [OUT_W_DEF-1:0] data;
        logic [CNT_W_DEF-1:0] count;
        logic                 sat;
    } result_t;
    typedef enum logic {IDLE, SUM} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sat_round_shift.sv
// sat_round_shift: round-half-up right shift by SH with saturation to OUT_W bits
module sat_round_shift #(
    parameter int IN_W = 27,
    parameter int SH = 5,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);
    localparam int RW = IN_W + 1 - SH;
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);
    logic [RW-1:0] r;
    assign r = RW'(({1'b0, value} + HALF) >> SH);
    generate
        if (RW > OUT_W) begin : g_wide
            assign ovf = |r[RW-1:OUT_W];
            assign result = ovf ? '1 : r[OUT_W-1:0];
        end else begin : g_narrow
            assign ovf = 1'b0;
            assign result = OUT_W'(r);
        end
    endgenerate
endmodule

// File: rtl/softmax_sum_accum.sv
// softmax_sum_accum: multi-lane saturating frame sum with rounded output and 2-entry result queue
module softmax_sum_accum
    import softmax_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W = 16,
    parameter int IN_FRAC = IN_FRAC_DEF,
    parameter int ACC_INT = 11,
    parameter int OUT_W = OUT_W_DEF,
    parameter int OUT_FRAC = OUT_FRAC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iLast,
    input  logic [LANES-1:0]      iKeep,
    input  logic [LANES*IN_W-1:0] iData,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [OUT_W-1:0]      oData,
    output logic [CNT_W-1:0]      oCount,
    output logic                  oSat
);
    localparam int ACC_W = ACC_INT + IN_FRAC;
    localparam int SH = IN_FRAC - OUT_FRAC;
    localparam int S1_W = IN_W + clog2(LANES) + 1;
    localparam int KC_W = clog2(LANES + 1);
    localparam int SUM_W = (ACC_W > S1_W ? ACC_W : S1_W) + 1;
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             sat;
    } rec_t;
    state_t           state;
    logic             run, accept, push, pop;
    logic [S1_W-1:0]  lane_sum, s1_sum;
    logic [KC_W-1:0]  kept, s1_cnt;
    logic             s1_valid, s1_last, s1_first;
    logic [ACC_W-1:0] acc, acc_next;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W:0]   cnt_sum;
    logic             sat, sat_next, acc_ovf, rnd_ovf;
    logic [OUT_W-1:0] rnd;
    rec_t             fresh;
    rec_t             q [2];
    logic [1:0]       q_cnt;
    always_comb begin
        lane_sum = '0;
        kept = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + (iKeep[k] ? S1_W'(iData[k*IN_W +: IN_W]) : S1_W'(0));
            kept = kept + KC_W'(iKeep[k]);
        end
    end
    // The first beat of a frame loads instead of adding, so no clear cycle is needed between frames
    assign acc_sum = (s1_first ? SUM_W'(0) : SUM_W'(acc)) + SUM_W'(s1_sum);
    assign acc_ovf = |acc_sum[SUM_W-1:ACC_W];
    assign acc_next = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
    assign cnt_sum = (s1_first ? '0 : {1'b0, cnt}) + (CNT_W + 1)'(s1_cnt);
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign sat_next = (!s1_first && sat) || acc_ovf;
    sat_round_shift #(.IN_W(ACC_W), .SH(SH), .OUT_W(OUT_W)) u_round (
        .value (acc_next),
        .result(rnd),
        .ovf   (rnd_ovf)
    );
    assign fresh = '{data: rnd, count: cnt_next, sat: sat_next || rnd_ovf};
    assign push = s1_valid && s1_last;
    assign pop = (q_cnt != 2'd0) && iReady;
    // In-flight closing beats reserve a queue slot, so a push never finds the queue full
    assign oReady = run && (q_cnt + {1'b0, push}) < 2'd2;
    assign accept = iValid && oReady;
    assign oValid = q_cnt != 2'd0;
    assign oData = q[0].data;
    assign oCount = q[0].count;
    assign oSat = q[0].sat;
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            run <= 1'b0;
            s1_valid <= 1'b0;
            s1_last <= 1'b0;
            s1_first <= 1'b0;
            s1_sum <= '0;
            s1_cnt <= '0;
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
            q_cnt <= '0;
            q[0] <= '0;
            q[1] <= '0;
        end else begin
            run <= 1'b1;
            s1_valid <= accept;
            s1_last <= accept && iLast;
            s1_first <= state == IDLE;
            s1_sum <= lane_sum;
            s1_cnt <= kept;
            if (accept) state <= iLast ? IDLE : SUM;
            if (s1_valid) begin
                acc <= acc_next;
                cnt <= cnt_next;
                sat <= sat_next;
            end
            if (pop) q[0] <= q_cnt == 2'd2 ? q[1] : fresh;
            else if (push && q_cnt == 2'd0) q[0] <= fresh;
            if (push && q_cnt == (pop ? 2'd2 : 2'd1)) q[1] <= fresh;
            q_cnt <= q_cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_softmax_sum_accum.sv
// tb_softmax_sum_accum: directed and randomized checks against a frame-level arithmetic model
module tb_softmax_sum_accum;
    import softmax_pkg::*;
    localparam longint ACC_MAX = (64'd1 << 27) - 1;
    logic        iClk = 1'b0, iRst = 1'b1, iValid = 1'b0, iLast = 1'b0, iReady = 1'b1;
    logic [3:0]  iKeep = '0;
    logic [63:0] iData = '0;
    logic        oReady, oValid, oSat;
    logic [15:0] oData;
    logic [11:0] oCount;
    int          errors = 0, checks = 0;
    bit          rand_rdy = 1'b0, hold_pend = 1'b0;
    logic [28:0] held;
    result_t     exp_q[$];
    longint      f_sum = 0;
    int          f_cnt = 0;
    bit          f_sat = 1'b0;

    softmax_sum_accum dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iLast(iLast),
        .iKeep(iKeep), .iData(iData), .oValid(oValid), .iReady(iReady),
        .oData(oData), .oCount(oCount), .oSat(oSat)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [3:0] keep, input logic [63:0] data, input logic last);
        result_t r;
        longint  q;
        for (int k = 0; k < 4; k++)
            if (keep[k]) begin
                f_sum += longint'(data[k*16 +: 16]);
                f_cnt++;
            end
        if (f_sum > ACC_MAX) begin
            f_sum = ACC_MAX;
            f_sat = 1'b1;
        end
        if (f_cnt > 4095) f_cnt = 4095;
        if (last) begin
            q = (f_sum + 16) / 32;
            r.sat = f_sat || q > 65535;
            r.data = q > 65535 ? 16'hFFFF : q[15:0];
            r.count = f_cnt[11:0];
            exp_q.push_back(r);
            f_sum = 0;
            f_cnt = 0;
            f_sat = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat
    task automatic send(input logic [3:0] keep, input logic [63:0] data, input logic last);
        logic rdy;
        int   n;
        n = 0;
        iValid = 1'b1;
        iKeep = keep;
        iData = data;
        iLast = last;
        do begin
            if (rand_rdy) iReady = 1'($urandom_range(0, 1));
            @(negedge iClk);
            rdy = oReady;
            @(posedge iClk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (rdy) model_accept(keep, data, last);
        else chk("send_timeout", 32'(rdy), 32'd1);
        iValid = 1'b0;
    endtask

    task automatic send_check(input string tag, input logic [3:0] keep, input logic [63:0] data,
                              input logic [15:0] ed, input logic [11:0] ec, input logic es);
        send(keep, data, 1'b1);
        @(negedge iClk);
        chk({tag, "_early"}, 32'(oValid), 32'd0);
        @(negedge iClk);
        chk({tag, "_valid"}, 32'(oValid), 32'd1);
        chk({tag, "_data"}, 32'(oData), 32'(ed));
        chk({tag, "_count"}, 32'(oCount), 32'(ec));
        chk({tag, "_sat"}, 32'(oSat), 32'(es));
        @(posedge iClk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        iValid = 1'b0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge iClk);
            #1;
            if (rand_rdy) iReady = 1'($urandom_range(0, 1));
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every consumed result must match the model, held results must not change
    always @(negedge iClk) begin
        if (iRst) hold_pend = 1'b0;
        else begin
            if (hold_pend) begin
                chk("hold_valid", 32'(oValid), 32'd1);
                chk("hold_payload", 32'({oData, oCount, oSat}), 32'(held));
            end
            if (oValid && iReady) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result observed=%h expected=none", oData);
                end
                if (exp_q.size() != 0) begin
                    chk("res_data", 32'(oData), 32'(exp_q[0].data));
                    chk("res_count", 32'(oCount), 32'(exp_q[0].count));
                    chk("res_sat", 32'(oSat), 32'(exp_q[0].sat));
                    void'(exp_q.pop_front());
                end
            end
            hold_pend = oValid && !iReady;
            held = {oData, oCount, oSat};
        end
    end

    initial begin
        logic [63:0] d [3];
        int len;
        @(posedge iClk);
        #1;
        @(negedge iClk);
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_data", 32'(oData), 32'd0);
        chk("rst_count", 32'(oCount), 32'd0);
        chk("rst_sat", 32'(oSat), 32'd0);
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        @(posedge iClk);
        #1;
        @(negedge iClk);
        chk("post_rst_ready", 32'(oReady), 32'd1);
        @(posedge iClk);
        #1;
        send_check("sum", 4'hF, 64'h8000_8000_8000_8000, 16'h1000, 12'd4, 1'b0);
        send_check("rnd_half", 4'h1, 64'hABCD_1234_5678_0010, 16'h0001, 12'd1, 1'b0);
        send_check("rnd_below", 4'h1, 64'hABCD_1234_5678_000F, 16'h0000, 12'd1, 1'b0);
        for (int i = 0; i < 31; i++) send(4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_check("out_sat", 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 12'd128, 1'b1);
        send_check("after_sat", 4'hF, 64'h2000_2000_2000_2000, 16'h0400, 12'd4, 1'b0);
        for (int i = 0; i < 1029; i++) send(4'hF, 64'h0001_0001_0001_0001, 1'b0);
        send_check("cnt_sat", 4'hF, 64'h0001_0001_0001_0001, 16'h0081, 12'hFFF, 1'b0);
        send_check("empty", 4'h0, 64'h1234_5678_9ABC_DEF0, 16'h0000, 12'd0, 1'b0);
        // Backpressure: two results fill the queue, the third frame waits
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
        iReady = 1'b0;
        send(4'hF, d[0], 1'b1);
        send(4'hF, d[1], 1'b1);
        iValid = 1'b1;
        iKeep = 4'hF;
        iData = d[2];
        iLast = 1'b1;
        @(negedge iClk);
        chk("bp_ready_low", 32'(oReady), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge iClk);
            #1;
            @(negedge iClk);
            chk("bp_full_valid", 32'(oValid), 32'd1);
            chk("bp_full_ready", 32'(oReady), 32'd0);
            chk("bp_head_data", 32'(oData), 32'(exp_q[0].data));
            chk("bp_depth", 32'(exp_q.size()), 32'd2);
        end
        @(posedge iClk);
        #1;
        iReady = 1'b1;
        send(4'hF, d[2], 1'b1);
        drain();
        // Adjacent frames: B starts the cycle after A closes
        send(4'hF, {$urandom, $urandom}, 1'b1);
        send(4'hF, {$urandom, $urandom}, 1'b0);
        send(4'hA, {$urandom, $urandom}, 1'b1);
        drain();
        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) send(4'hF, 64'h7000_7000_7000_7000, 1'b0);
        iRst = 1'b1;
        @(negedge iClk);
        @(posedge iClk);
        #1;
        @(negedge iClk);
        chk("mid_rst_ready", 32'(oReady), 32'd0);
        chk("mid_rst_valid", 32'(oValid), 32'd0);
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        f_sum = 0;
        f_cnt = 0;
        f_sat = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            chk("mid_rst_no_result", 32'(oValid), 32'd0);
        end
        @(posedge iClk);
        #1;
        send_check("after_rst", 4'hF, 64'h4000_4000_4000_4000, 16'h0800, 12'd4, 1'b0);
        // Randomized frames with random output backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++)
                send(4'($urandom), {$urandom, $urandom}, 1'(b == len - 1));
        end
        drain();
        rand_rdy = 1'b0;
        iReady = 1'b1;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
